// File: rtl/rgb_pwm_ctrl.sv
// CPU-programmable three-channel PWM generator for the RGB LED driver.
// Supports off, static, blink and breathe modes with per-frame shadowed settings.
module rgb_pwm_ctrl #(
  parameter int PRESCALE = 62
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [2:0] rgb_pwm
);

  localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  logic [PW-1:0] r_pre;
  logic [7:0]    r_pcnt;
  logic [1:0]    r_mode;
  logic [7:0]    r_rate;
  logic [7:0]    r_duty  [3];
  logic [7:0]    r_sduty [3];
  logic [1:0]    r_smode;
  logic [7:0]    r_stepcnt;
  logic [7:0]    r_env;
  logic          r_dir;
  logic          r_phase;

  logic          w_wr;
  logic          w_rd;
  logic          w_ctrl_wr;
  logic          w_tick;
  logic          w_frame_start;
  logic          w_step;
  logic [7:0]    w_rate_cap;
  logic [1:0]    w_mode_cap;
  logic [7:0]    w_duty_cap [3];
  logic [7:0]    w_eff      [3];
  logic [7:0]    w_rdata;

  assign w_wr          = cs & we;
  assign w_rd          = cs & ~we;
  assign w_ctrl_wr     = w_wr & (addr == 3'd0);
  assign w_tick        = (r_pre == PW'(PRESCALE));
  assign w_frame_start = w_tick & (r_pcnt == 8'hFF);

  // Values captured at frame start; a write landing on that very edge wins.
  always_comb begin
    w_mode_cap = r_mode;
    w_rate_cap = r_rate;
    if (w_ctrl_wr) begin
      w_mode_cap = din[1:0];
    end else begin
      w_mode_cap = r_mode;
    end
    if (w_wr && (addr == 3'd4)) begin
      w_rate_cap = din;
    end else begin
      w_rate_cap = r_rate;
    end
    for (int n = 0; n < 3; n++) begin
      if (w_wr && (addr == 3'(n + 1))) begin
        w_duty_cap[n] = din;
      end else begin
        w_duty_cap[n] = r_duty[n];
      end
    end
  end

  assign w_step = w_frame_start & (r_stepcnt >= w_rate_cap);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre  <= '0;
      r_pcnt <= 8'h00;
    end else if (w_tick) begin
      r_pre  <= '0;
      r_pcnt <= r_pcnt + 8'd1;
    end else begin
      r_pre  <= r_pre + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= 2'b00;
      r_rate <= 8'h00;
      for (int n = 0; n < 3; n++) r_duty[n] <= 8'h00;
    end else if (w_wr) begin
      case (addr)
        3'd0:    r_mode    <= din[1:0];
        3'd1:    r_duty[0] <= din;
        3'd2:    r_duty[1] <= din;
        3'd3:    r_duty[2] <= din;
        3'd4:    r_rate    <= din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_smode <= 2'b00;
      for (int n = 0; n < 3; n++) r_sduty[n] <= 8'h00;
    end else if (w_frame_start) begin
      r_smode <= w_mode_cap;
      for (int n = 0; n < 3; n++) r_sduty[n] <= w_duty_cap[n];
    end
  end

  // Effect sequencer; a CTRL write restarts the effect and drops a coincident step.
  always_ff @(posedge clk) begin
    if (reset || w_ctrl_wr) begin
      r_stepcnt <= 8'h00;
      r_env     <= 8'h00;
      r_dir     <= 1'b0;
      r_phase   <= 1'b0;
    end else if (w_frame_start) begin
      r_stepcnt <= w_step ? 8'h00 : r_stepcnt + 8'd1;
      if (w_step) begin
        case (r_mode)
          2'b10: r_phase <= ~r_phase;
          2'b11: begin
            if (!r_dir) begin
              if (r_env != 8'hFF) r_env <= r_env + 8'd1;
              if (r_env >= 8'hFE) r_dir <= 1'b1;
            end else begin
              if (r_env != 8'h00) r_env <= r_env - 8'd1;
              if (r_env <= 8'h01) r_dir <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      w_eff[n] = 8'h00;
      case (r_smode)
        2'b01:   w_eff[n] = r_sduty[n];
        2'b10:   w_eff[n] = r_phase ? r_sduty[n] : 8'h00;
        2'b11:   w_eff[n] = 8'((16'(r_sduty[n]) * 16'(r_env)) >> 8);
        default: w_eff[n] = 8'h00;
      endcase
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    case (addr)
      3'd0:    w_rdata = {6'b000000, r_mode};
      3'd1:    w_rdata = r_duty[0];
      3'd2:    w_rdata = r_duty[1];
      3'd3:    w_rdata = r_duty[2];
      3'd4:    w_rdata = r_rate;
      3'd5:    w_rdata = r_env;
      3'd6:    w_rdata = {6'b000000, r_dir, r_phase};
      default: w_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout    <= 8'h00;
      rgb_pwm <= 3'b000;
    end else begin
      if (w_rd) dout <= w_rdata;
      for (int n = 0; n < 3; n++) rgb_pwm[n] <= (r_pcnt < w_eff[n]);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed self-checking bench for rgb_pwm_ctrl, run with PRESCALE=0 so a frame is 256 clocks.
module tb_rgb_pwm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic [2:0] rgb_pwm;
  logic [7:0] tb_pcnt;
  int         checks;
  int         failures;

  rgb_pwm_ctrl #(.PRESCALE(0)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr),
    .din(din), .dout(dout), .rgb_pwm(rgb_pwm)
  );

  always #5 clk = ~clk;

  // Free-running frame position, restarted by reset only.
  always @(posedge clk) tb_pcnt <= reset ? 8'd0 : tb_pcnt + 8'd1;

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk); cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk); cs = 1'b0;
    d = dout;
  endtask

  // Passes exactly one frame start and returns on the negedge where pcnt==1.
  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (tb_pcnt != 8'd1 && n < 300);
    if (tb_pcnt != 8'd1) begin
      checks++; failures++;
      $display("FAIL wait_fs: timeout, pcnt=%0d required 1", tb_pcnt);
    end
  endtask

  // High counts per channel over the frame that begins at the next frame start.
  task automatic count_frame(output int c0, output int c1, output int c2);
    wait_fs();
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 256; i++) begin
      if (i != 0) @(negedge clk);
      c0 += int'(rgb_pwm[0]); c1 += int'(rgb_pwm[1]); c2 += int'(rgb_pwm[2]);
    end
  endtask

  task automatic wait_pcnt(input logic [7:0] v);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (tb_pcnt != v && n < 300);
    if (tb_pcnt != v) begin
      checks++; failures++;
      $display("FAIL wait_pcnt: timeout, pcnt=%0d required %0d", tb_pcnt, v);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int ones;
    reset = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (dout !== 8'h00 || rgb_pwm !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs: dout=%h rgb=%b required 00 000", dout, rgb_pwm);
    end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      checks++;
      if (d !== 8'h00) begin
        failures++;
        $display("FAIL reset_read[%0d]: got %h required 00", a, d);
      end
    end
    ones = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (rgb_pwm !== 3'b000) ones++;
    end
    checks++;
    if (ones != 0) begin
      failures++;
      $display("FAIL reset_idle_pwm: %0d active samples required 0", ones);
    end
  endtask

  task automatic test_regs();
    logic [7:0] d;
    bus_write(3'd1, 8'h5A); bus_read(3'd1, d);
    checks++;
    if (d !== 8'h5A) begin failures++; $display("FAIL reg_duty0: got %h required 5a", d); end
    bus_write(3'd4, 8'h07); bus_read(3'd4, d);
    checks++;
    if (d !== 8'h07) begin failures++; $display("FAIL reg_rate: got %h required 07", d); end
    bus_write(3'd0, 8'hFF); bus_read(3'd0, d);
    checks++;
    if (d !== 8'h03) begin failures++; $display("FAIL reg_ctrl_mask: got %h required 03", d); end
    bus_write(3'd0, 8'h00);
    bus_write(3'd6, 8'hFF); bus_read(3'd6, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reg_phase_ro: got %h required 00", d); end
    bus_write(3'd7, 8'hFF); bus_read(3'd7, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reg_addr7: got %h required 00", d); end
    bus_write(3'd4, 8'h00);
    bus_write(3'd1, 8'h00);
  endtask

  task automatic test_static();
    int c0, c1, c2;
    bus_write(3'd1, 8'h40); bus_write(3'd2, 8'h00); bus_write(3'd3, 8'hFF);
    bus_write(3'd0, 8'h01);
    count_frame(c0, c1, c2);
    checks++;
    if (c0 != 64) begin failures++; $display("FAIL static_ch0: got %0d required 64", c0); end
    checks++;
    if (c1 != 0) begin failures++; $display("FAIL static_ch1: got %0d required 0", c1); end
    checks++;
    if (c2 != 255) begin failures++; $display("FAIL static_ch2: got %0d required 255", c2); end
    count_frame(c0, c1, c2);
    checks++;
    if (c0 != 64) begin failures++; $display("FAIL static_ch0_again: got %0d required 64", c0); end
  endtask

  task automatic test_midframe_duty();
    int c0, c1, c2;
    wait_fs();
    c0 = 0;
    for (int i = 0; i < 256; i++) begin
      if (i != 0) @(negedge clk);
      c0 += int'(rgb_pwm[0]);
      if (i == 100) begin cs = 1'b1; we = 1'b1; addr = 3'd1; din = 8'h80; end
      if (i == 101) begin cs = 1'b0; we = 1'b0; end
    end
    checks++;
    if (c0 != 64) begin failures++; $display("FAIL midframe_old: got %0d required 64", c0); end
    count_frame(c0, c1, c2);
    checks++;
    if (c0 != 128) begin failures++; $display("FAIL midframe_new: got %0d required 128", c0); end
  endtask

  task automatic test_duty_at_frame_start();
    int c0, c1, c2;
    wait_pcnt(8'd255);
    cs = 1'b1; we = 1'b1; addr = 3'd2; din = 8'h10;
    @(negedge clk); cs = 1'b0; we = 1'b0;
    count_frame(c0, c1, c2);
    checks++;
    if (c1 != 16) begin failures++; $display("FAIL duty_at_fs: got %0d required 16", c1); end
  endtask

  task automatic test_blink();
    int c0, c1, c2;
    int exp_c1 [6];
    logic [7:0] d;
    exp_c1 = '{0, 255, 255, 0, 0, 255};
    bus_write(3'd2, 8'hFF); bus_write(3'd4, 8'h01); bus_write(3'd0, 8'h02);
    for (int f = 0; f < 6; f++) begin
      count_frame(c0, c1, c2);
      checks++;
      if (c1 != exp_c1[f]) begin
        failures++;
        $display("FAIL blink_frame[%0d]: got %0d required %0d", f + 1, c1, exp_c1[f]);
      end
    end
    wait_fs(); bus_read(3'd6, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL blink_phase_hi: got %h required 01", d); end
    wait_fs(); bus_read(3'd6, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL blink_phase_lo: got %h required 00", d); end
  endtask

  task automatic test_breathe();
    int c0, c1, c2;
    logic [7:0] d;
    bus_write(3'd4, 8'h00); bus_write(3'd0, 8'h03);
    for (int k = 1; k <= 3; k++) begin
      count_frame(c0, c1, c2);
      checks++;
      if (c2 != k - 1) begin failures++; $display("FAIL breathe_ramp[%0d]: got %0d required %0d", k, c2, k - 1); end
    end
    for (int k = 4; k <= 255; k++) begin
      wait_fs();
      if (k == 100 || k == 255) begin
        bus_read(3'd5, d);
        checks++;
        if (d !== 8'(k)) begin failures++; $display("FAIL breathe_status[%0d]: got %h required %h", k, d, 8'(k)); end
        bus_read(3'd6, d);
        checks++;
        if (d !== ((k == 255) ? 8'h02 : 8'h00)) begin
          failures++;
          $display("FAIL breathe_dir[%0d]: got %h required %h", k, d, (k == 255) ? 8'h02 : 8'h00);
        end
      end
    end
    count_frame(c0, c1, c2);
    checks++;
    if (c2 != 253) begin failures++; $display("FAIL breathe_descend: got %0d required 253", c2); end
  endtask

  task automatic test_ctrl_clear();
    int c0, c1, c2;
    logic [7:0] d;
    wait_fs(); bus_read(3'd5, d);
    checks++;
    if (d !== 8'd253) begin failures++; $display("FAIL clear_pre_status: got %h required fd", d); end
    bus_write(3'd0, 8'h03);
    bus_read(3'd5, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL clear_status: got %h required 00", d); end
    bus_read(3'd6, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL clear_phase: got %h required 00", d); end
    for (int k = 1; k <= 3; k++) begin
      count_frame(c0, c1, c2);
      checks++;
      if (c2 != k - 1) begin failures++; $display("FAIL clear_ramp[%0d]: got %0d required %0d", k, c2, k - 1); end
    end
  endtask

  task automatic test_reset_midframe();
    int c0, c1, c2;
    logic [7:0] d;
    bus_write(3'd0, 8'h01);
    wait_fs();
    wait_pcnt(8'd10);
    checks++;
    if (rgb_pwm !== 3'b111) begin failures++; $display("FAIL pre_reset_pwm: got %b required 111", rgb_pwm); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (rgb_pwm !== 3'b000) begin failures++; $display("FAIL reset_mid_pwm: got %b required 000", rgb_pwm); end
    bus_read(3'd1, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reset_mid_duty0: got %h required 00", d); end
    count_frame(c0, c1, c2);
    checks++;
    if (c0 + c1 + c2 != 0) begin failures++; $display("FAIL reset_mid_frame: got %0d required 0", c0 + c1 + c2); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_regs();
    test_static();
    test_midframe_duty();
    test_duty_at_frame_start();
    test_blink();
    test_breathe();
    test_ctrl_clear();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
